// File: rtl/wb_trace_pkg.sv
// Shared definitions for the write-back retire-trace unit.
// Holds trace record field widths, the packed commit record, the
// finish-instruction defaults and a helper that builds a record from
// raw WB-stage signals.
package wb_trace_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned WREN_W   = 1;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TRC_W    = PC_W + INST_W + WREN_W + ADDR_W + DATA_W;

    // pc+4 and encoding of the branch-to-self that ends a program
    localparam logic [PC_W-1:0]   FINISH_PC_4_DEF = 32'h0040_0054;
    localparam logic [INST_W-1:0] FINISH_INST_DEF = 32'h1000_ffff;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              wren;
        logic [ADDR_W-1:0] wraddr;
        logic [DATA_W-1:0] wrdata;
    } trc_rec_t;

    // Commit record for one retirement; writes to x0 are not real writes.
    function automatic trc_rec_t make_rec(
        input logic [PC_W-1:0]   pc_4,
        input logic [INST_W-1:0] inst,
        input logic              regwrite,
        input logic [ADDR_W-1:0] wraddr,
        input logic [DATA_W-1:0] wrdata
    );
        trc_rec_t r;
        r.pc     = pc_4 - PC_W'(4);
        r.inst   = inst;
        r.wren   = regwrite & (wraddr != '0);
        r.wraddr = wraddr;
        r.wrdata = wrdata;
        return r;
    endfunction

endpackage

// File: rtl/trc_fifo.sv
// First-word-fall-through FIFO for trace records.
// The head entry is held in a register (dout/valid) so the outputs are
// registered; a push into an empty FIFO shows up on dout one cycle later.
// dout reads 0 while the FIFO is empty.
// Ports: clk, rst_n (async, active-low), push/din (write, caller ensures
// not full or popping), pop (read, caller ensures valid), dout/valid
// (head record), full, level (occupancy 0..DEPTH).
module trc_fifo #(
    parameter int unsigned WIDTH = 102,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW-1:0]    rd_ptr_nxt, wr_ptr_nxt;
    logic [LW-1:0]    cnt_after_pop, cnt_nxt;
    logic [WIDTH-1:0] head_nxt;

    // Next pointers/occupancy and the record that will sit at the head
    always_comb begin
        rd_ptr_nxt    = pop  ? rd_ptr + AW'(1) : rd_ptr;
        wr_ptr_nxt    = push ? wr_ptr + AW'(1) : wr_ptr;
        cnt_after_pop = level - LW'(pop);
        cnt_nxt       = cnt_after_pop + LW'(push);
        head_nxt      = '0;
        if (cnt_nxt != '0) begin
            // Only the incoming word remains: it cannot be in mem yet
            if (cnt_after_pop == '0) head_nxt = din;
            else                     head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
            level  <= cnt_nxt;
            full   <= (cnt_nxt == LW'(DEPTH));
            valid  <= (cnt_nxt != '0);
            dout   <= head_nxt;
        end
    end

endmodule

// File: rtl/wb_trace.sv
// Retire-trace unit sitting behind the pipeline's WB stage.
// Captures one commit record per retirement into an FWFT FIFO and streams
// them out on a valid/ready port; counts retirements and dropped records
// and flags the program-finish instruction.
// Ports: ret_* (retiring instruction from WB), trc_valid/trc_ready and
// trc_* (head record stream), level (FIFO occupancy), retired_cnt,
// drop_cnt (saturating), overflow and finish (both sticky until reset).
module wb_trace
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter logic [31:0] FINISH_PC_4 = FINISH_PC_4_DEF,
    parameter logic [31:0] FINISH_INST = FINISH_INST_DEF,
    parameter int unsigned DROPW       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ret_valid,
    input  logic [31:0]              ret_pc_4,
    input  logic [31:0]              ret_inst,
    input  logic                     ret_regwrite,
    input  logic [4:0]               ret_wraddr,
    input  logic [31:0]              ret_wrdata,
    output logic                     trc_valid,
    input  logic                     trc_ready,
    output logic [31:0]              trc_pc,
    output logic [31:0]              trc_inst,
    output logic                     trc_wren,
    output logic [4:0]               trc_wraddr,
    output logic [31:0]              trc_wrdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              retired_cnt,
    output logic [DROPW-1:0]         drop_cnt,
    output logic                     overflow,
    output logic                     finish
);

    logic             cap, pop, push, drop, fin_hit;
    logic             fifo_full;
    trc_rec_t         rec_in, rec_out;
    logic [TRC_W-1:0] fifo_dout;

    // Capture qualification and FIFO handshake
    always_comb begin
        cap     = ret_valid & ~finish;
        pop     = trc_valid & trc_ready;
        // A pop in the same cycle frees a slot in a full FIFO
        push    = cap & (~fifo_full | pop);
        drop    = cap & fifo_full & ~pop;
        fin_hit = cap & (ret_pc_4 == FINISH_PC_4) & (ret_inst == FINISH_INST);
        rec_in  = make_rec(ret_pc_4, ret_inst, ret_regwrite, ret_wraddr, ret_wrdata);
    end

    trc_fifo #(
        .WIDTH (TRC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (rec_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (trc_valid),
        .full  (fifo_full),
        .level (level)
    );

    // Head record fields (registered inside the FIFO, zero when empty)
    always_comb begin
        rec_out    = trc_rec_t'(fifo_dout);
        trc_pc     = rec_out.pc;
        trc_inst   = rec_out.inst;
        trc_wren   = rec_out.wren;
        trc_wraddr = rec_out.wraddr;
        trc_wrdata = rec_out.wrdata;
    end

    // Retirement/drop counters and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            drop_cnt    <= '0;
            overflow    <= 1'b0;
            finish      <= 1'b0;
        end else begin
            if (cap) retired_cnt <= retired_cnt + 32'd1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + DROPW'(1);
            end
            if (fin_hit) finish <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_trace.sv
// Self-checking bench for wb_trace: a queue-based reference model is
// compared against the DUT on every falling edge, plus literal checks on
// directed scenarios and a randomized phase.
module tb_wb_trace;
    import wb_trace_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DROPW = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ret_valid = 1'b0;
    logic [31:0]       ret_pc_4 = '0;
    logic [31:0]       ret_inst = '0;
    logic              ret_regwrite = 1'b0;
    logic [4:0]        ret_wraddr = '0;
    logic [31:0]       ret_wrdata = '0;
    logic              trc_valid;
    logic              trc_ready = 1'b0;
    logic [31:0]       trc_pc, trc_inst, trc_wrdata;
    logic              trc_wren;
    logic [4:0]        trc_wraddr;
    logic [LW-1:0]     level;
    logic [31:0]       retired_cnt;
    logic [DROPW-1:0]  drop_cnt;
    logic              overflow, finish;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    wb_trace #(
        .DEPTH       (DEPTH),
        .FINISH_PC_4 (32'h0040_0054),
        .FINISH_INST (32'h1000_ffff),
        .DROPW       (DROPW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ret_valid    (ret_valid),
        .ret_pc_4     (ret_pc_4),
        .ret_inst     (ret_inst),
        .ret_regwrite (ret_regwrite),
        .ret_wraddr   (ret_wraddr),
        .ret_wrdata   (ret_wrdata),
        .trc_valid    (trc_valid),
        .trc_ready    (trc_ready),
        .trc_pc       (trc_pc),
        .trc_inst     (trc_inst),
        .trc_wren     (trc_wren),
        .trc_wraddr   (trc_wraddr),
        .trc_wrdata   (trc_wrdata),
        .level        (level),
        .retired_cnt  (retired_cnt),
        .drop_cnt     (drop_cnt),
        .overflow     (overflow),
        .finish       (finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    trc_rec_t         mq[$];
    logic [31:0]      m_ret  = '0;
    logic [DROPW-1:0] m_drop = '0;
    bit               m_ovf  = 1'b0;
    bit               m_fin  = 1'b0;
    bit               m_cap, m_full, m_pop;
    trc_rec_t         m_rec;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ret  = '0;
            m_drop = '0;
            m_ovf  = 1'b0;
            m_fin  = 1'b0;
        end else begin
            m_cap  = ret_valid && !m_fin;
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() != 0) && trc_ready;
            if (m_pop) void'(mq.pop_front());
            if (m_cap) begin
                m_rec.pc     = ret_pc_4 - 32'd4;
                m_rec.inst   = ret_inst;
                m_rec.wren   = ret_regwrite && (ret_wraddr != 5'd0);
                m_rec.wraddr = ret_wraddr;
                m_rec.wrdata = ret_wrdata;
                if (!m_full || m_pop) mq.push_back(m_rec);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != {DROPW{1'b1}}) m_drop = m_drop + 1'b1;
                end
                m_ret = m_ret + 32'd1;
                if (ret_pc_4 == 32'h0040_0054 && ret_inst == 32'h1000_ffff) m_fin = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    trc_rec_t exp_head;
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            exp_head = (mq.size() != 0) ? mq[0] : '0;
            chk("trc_valid", trc_valid, mq.size() != 0);
            chk("trc_payload", {trc_pc, trc_inst, trc_wren, trc_wraddr, trc_wrdata}, exp_head);
            chk("level", level, mq.size());
            chk("retired_cnt", retired_cnt, m_ret);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("overflow", overflow, m_ovf);
            chk("finish", finish, m_fin);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ret(input bit v, input logic [31:0] pc4, input logic [31:0] inst,
                       input bit rw, input logic [4:0] wa, input logic [31:0] wd);
        step();
        ret_valid    = v;
        ret_pc_4     = pc4;
        ret_inst     = inst;
        ret_regwrite = rw;
        ret_wraddr   = wa;
        ret_wrdata   = wd;
    endtask

    task automatic idle();
        ret(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_valid"}, trc_valid, 0);
        chk({tag, "_payload"}, {trc_pc, trc_inst, trc_wren, trc_wraddr, trc_wrdata}, 0);
        chk({tag, "_retired"}, retired_cnt, 0);
        chk({tag, "_drop"}, drop_cnt, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_finish"}, finish, 0);
    endtask

    task automatic do_reset();
        step();
        ret_valid = 1'b0;
        trc_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fill10(input logic [31:0] base);
        for (int i = 0; i < 10; i++)
            ret(1'b1, base + 32'(4 * (i + 1)), 32'(i), 1'b1, 5'(i + 1), 32'(100 + i));
        idle();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Basic streaming: three back-to-back captures, consumer always ready
        trc_ready = 1'b1;
        ret(1'b1, 32'h0040_0004, 32'h0000_0001, 1'b1, 5'd5, 32'h11);
        ret(1'b1, 32'h0040_0008, 32'h0000_0002, 1'b1, 5'd6, 32'h22);
        chk("basic_pc0", trc_pc, 32'h0040_0000);
        chk("basic_wren0", trc_wren, 1);
        ret(1'b1, 32'h0040_000c, 32'h0000_0003, 1'b1, 5'd0, 32'h33);
        chk("basic_pc1", trc_pc, 32'h0040_0004);
        chk("basic_wren1", trc_wren, 1);
        idle();
        chk("basic_pc2", trc_pc, 32'h0040_0008);
        chk("basic_wren2", trc_wren, 0);
        idle();
        chk("basic_level", level, 0);
        chk("basic_retired", retired_cnt, 3);

        // Fill and overflow, then push+pop while full, then drain
        do_reset();
        fill10(32'h1000);
        chk("fill_level", level, 8);
        chk("fill_drop", drop_cnt, 2);
        chk("fill_ovf", overflow, 1);
        chk("fill_retired", retired_cnt, 10);
        ret(1'b1, 32'h2004, 32'habcd, 1'b1, 5'd9, 32'h99);
        trc_ready = 1'b1;
        idle();
        trc_ready = 1'b0;
        chk("fullpp_level", level, 8);
        chk("fullpp_drop", drop_cnt, 2);
        chk("fullpp_head", trc_pc, 32'h1004);
        trc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_pc", trc_pc, (i < 7) ? 32'(32'h1004 + 4 * i) : 32'h2000);
            step();
        end
        trc_ready = 1'b0;
        chk("drain_valid", trc_valid, 0);

        // Near-miss and real finish
        do_reset();
        ret(1'b1, 32'h0040_0054, 32'h1000_fffe, 1'b0, 5'd0, 0);
        ret(1'b1, 32'h0040_0050, 32'h1000_ffff, 1'b0, 5'd0, 0);
        chk("nearmiss1_finish", finish, 0);
        ret(1'b1, 32'h0040_0054, 32'h1000_ffff, 1'b0, 5'd0, 0);
        chk("nearmiss2_finish", finish, 0);
        ret(1'b1, 32'h0040_0058, 32'h1, 1'b1, 5'd1, 1);
        chk("finish_set", finish, 1);
        chk("finish_retired", retired_cnt, 3);
        ret(1'b1, 32'h0040_005c, 32'h2, 1'b1, 5'd2, 2);
        ret(1'b1, 32'h0040_0060, 32'h3, 1'b1, 5'd3, 3);
        idle();
        chk("finish_retired_after", retired_cnt, 3);
        chk("finish_level", level, 3);
        chk("finish_sticky", finish, 1);

        // Reset mid-operation with queued records and overflow set
        do_reset();
        fill10(32'h3000);
        trc_ready = 1'b1;
        repeat (3) step();
        trc_ready = 1'b0;
        chk("midrst_pre_level", level, 5);
        chk("midrst_pre_ovf", overflow, 1);
        #1 rst_n = 1'b0;
        #1 check_zero("midrst");
        rst_n = 1'b1;

        // Randomized phase
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int c = 0; c < 500; c++) begin
                step();
                ret_valid    = ($urandom % 4) != 0;
                ret_pc_4     = ($urandom % 64 == 0) ? 32'h0040_0054 : $urandom;
                ret_inst     = ($urandom % 4 == 0) ? 32'h1000_ffff : $urandom;
                ret_regwrite = 1'($urandom);
                ret_wraddr   = 5'($urandom);
                ret_wrdata   = $urandom;
                trc_ready    = (blk % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            end
        end
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_trace.md
Name: wb_trace

Overview:
- Retire-trace unit downstream of the 5-stage pipeline's WB stage.
- Each cycle it samples the instruction retiring at write-back.
- It buffers a commit record per retirement in a first-word-fall-through (FWFT) FIFO and streams records out on a valid/ready port to the test harness or debug logger.
- It also keeps the retired-instruction count, counts dropped records, and detects the program-finish instruction.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- FINISH_PC_4, 32'h00400054, pc+4 of the finish instruction.
- FINISH_INST, 32'h1000ffff, encoding of the finish instruction (branch-to-self).
- DROPW, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ret_valid  in  1  a non-bubble instruction is in WB this cycle.
- ret_pc_4  in  32  pc+4 of the retiring instruction.
- ret_inst  in  32  instruction word.
- ret_regwrite  in  1  WB register-write enable.
- ret_wraddr  in  5  destination register.
- ret_wrdata  in  32  write-back data.
- trc_valid  out  1  head record available.
- trc_ready  in  1  consumer accepts the head record.
- trc_pc  out  32  head record pc (ret_pc_4 - 4).
- trc_inst  out  32  head record instruction.
- trc_wren  out  1  head record register write (0 if wraddr==0).
- trc_wraddr  out  5  head record destination.
- trc_wrdata  out  32  head record data.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- retired_cnt  out  32  instructions retired since reset.
- drop_cnt  out  DROPW  records lost to a full FIFO; saturating.
- overflow  out  1  sticky; set on the first drop.
- finish  out  1  sticky; finish instruction retired.

Behaviour:
- Reset (async, rst_n=0) clears:
  - FIFO pointers, so level=0 and trc_valid=0.
  - All trc_* payload outputs to 0.
  - retired_cnt, drop_cnt, overflow and finish to 0.
- Reset mid-operation discards queued records immediately. There is no partial drain.
- Capture condition: cap = ret_valid & !finish. After finish=1, all retirements are ignored: not counted, not enqueued, not dropped.
- On cap, the record is {ret_pc_4-32'd4, ret_inst, ret_regwrite & (ret_wraddr!=0), ret_wraddr, ret_wrdata}. The pc subtraction is modulo 2^32.
- retired_cnt increments by 1 on every cap, wrapping at 2^32. It updates at the clock edge after the sample.
- Pop: pop = trc_valid & trc_ready.
- Push: push = cap & (!full | pop). When full, a simultaneous pop frees the slot, so the push is accepted and level is unchanged.
- Drop: cap & full & !pop.
  - drop_cnt increments and saturates at all-ones.
  - overflow <= 1.
  - retired_cnt still increments.
- Push and pop in the same cycle when not full or empty: level unchanged.
- Push when empty: the record appears on trc_* one cycle later. FWFT latency is 1; there is no same-cycle bypass.
- Pop when empty is impossible because trc_valid=0. trc_ready is ignored while trc_valid=0.
- trc_* payload is 0 whenever trc_valid=0.
- While trc_valid=1 and trc_ready=0, the payload holds stable.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH.
  - full  = level==DEPTH
  - empty = level==0
- Finish: if cap & ret_pc_4==FINISH_PC_4 & ret_inst==FINISH_INST, then finish <= 1 at that edge.
  - The finish record itself is enqueued, or dropped if full, like any other record.
  - finish stays 1 until reset.
- Output stream: the FIFO keeps draining after finish, so the consumer can empty it.
- Upstream pipeline stall: the WB stage repeats an instruction during a stall. The upstream block drives ret_valid=0 for repeated cycles; this block does not de-duplicate.

Decomposition:
- Shared header cpu_defs.vh holds:
  - FINISH_ADDR_PC_4 and FINISH_INST constants, used as parameter defaults.
  - Trace record field widths.
  - TRC_W = 32+32+1+5+32 = 102.
- One sub-module, trc_fifo: a synchronous FWFT FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, rst_n, push, din, pop, dout, valid, full, level.
- wb_trace keeps the following and instantiates trc_fifo:
  - capture qualification
  - counters
  - finish/overflow logic

Test Plan:
- Basic streaming:
  - Stimulus: reset, then 3 back-to-back captures (pc_4 = 0x00400004, 08, 0C; regwrite=1, wraddr=5, 6, 0) with trc_ready=1.
  - Response: records in order with trc_pc = 0x00400000, 04, 08; trc_wren = 1, 1, 0; retired_cnt=3; level returns to 0.
- Fill and overflow:
  - Stimulus: trc_ready=0, 10 captures with DEPTH=8.
  - Response: level=8, drop_cnt=2, overflow=1, retired_cnt=10. Draining yields exactly the first 8 records.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, one cycle with cap=1 and trc_ready=1.
  - Response: level stays 8, drop_cnt unchanged, and the new record appears last on drain.
- Finish detection:
  - Stimulus: capture pc_4=0x00400054, inst=0x1000ffff, then 3 more ret_valid cycles.
  - Response: finish=1 on the next edge; retired_cnt grows by 1 only; exactly one extra record in the FIFO.
- Near-miss finish:
  - Stimulus: pc_4 matches but inst=0x1000fffe, or inst matches but pc_4=0x00400050.
  - Response: finish stays 0.
- Reset mid-operation:
  - Stimulus: level=5, overflow=1, then pulse rst_n low between clock edges.
  - Response: level, trc_valid, trc_* payload, counters, overflow and finish all read 0 immediately, without waiting for clk.
